// File: rtl/cache_mem_arbiter.sv
// Shares one cache-line memory port between the icache and dcache: round-robin read bursts
// with one outstanding, plus a single-entry dcache write-back buffer with read-after-write hold.
module cache_mem_arbiter (
  input  logic         clk,
  input  logic         resetn,
  // icache read
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  output logic [31:0]  i_ret_data,
  // dcache read
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  d_ret_data,
  // dcache write-back
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  // bridge read channel
  output logic         axi_rd_req,
  output logic [2:0]   axi_rd_type,
  output logic [31:0]  axi_rd_addr,
  output logic         axi_rd_id,
  input  logic         axi_rd_rdy,
  input  logic         axi_ret_valid,
  input  logic         axi_ret_last,
  input  logic [31:0]  axi_ret_data,
  // bridge write channel
  output logic         axi_wr_req,
  output logic [2:0]   axi_wr_type,
  output logic [31:0]  axi_wr_addr,
  output logic [3:0]   axi_wr_wstrb,
  output logic [127:0] axi_wr_data,
  input  logic         axi_wr_rdy,
  input  logic         axi_wr_done
);

  typedef enum logic [2:0] {
    RIdle = 3'b001,
    RReq  = 3'b010,
    RResp = 3'b100
  } rd_state_e;

  typedef enum logic [1:0] {
    WIdle = 2'd0,
    WReq  = 2'd1,
    WWait = 2'd2
  } wr_state_e;

  rd_state_e      rd_state_q, rd_state_d;
  logic           rd_owner_q;
  logic [2:0]     rd_type_q;
  logic [31:0]    rd_addr_q;
  logic           last_grant_q;

  wr_state_e      wr_state_q, wr_state_d;
  logic [2:0]     wr_type_q;
  logic [31:0]    wr_addr_q;
  logic [3:0]     wr_wstrb_q;
  logic [127:0]   wr_data_q;

  logic           wr_busy;
  logic           i_elig;
  logic           d_elig;
  logic           grant_d;
  logic           rd_start;

  // A read to the line sitting in the write buffer must wait for the write response.
  assign wr_busy  = (wr_state_q != WIdle);
  assign i_elig   = i_rd_req && !(wr_busy && (i_rd_addr[31:4] == wr_addr_q[31:4]));
  assign d_elig   = d_rd_req && !(wr_busy && (d_rd_addr[31:4] == wr_addr_q[31:4]));
  assign grant_d  = d_elig && (!i_elig || !last_grant_q);
  assign rd_start = (rd_state_q == RIdle) && (i_elig || d_elig);

  assign axi_rd_type = rd_type_q;
  assign axi_rd_addr = rd_addr_q;
  assign axi_rd_id   = rd_owner_q;

  always_comb begin
    rd_state_d  = rd_state_q;
    axi_rd_req  = 1'b0;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    i_ret_data  = 32'd0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;
    d_ret_data  = 32'd0;
    unique case (rd_state_q)
      RIdle: begin
        if (i_elig || d_elig) rd_state_d = RReq;
      end
      RReq: begin
        axi_rd_req = 1'b1;
        i_rd_rdy   = !rd_owner_q && axi_rd_rdy;
        d_rd_rdy   = rd_owner_q && axi_rd_rdy;
        if (axi_rd_rdy) rd_state_d = RResp;
      end
      RResp: begin
        if (rd_owner_q) begin
          d_ret_valid = axi_ret_valid;
          d_ret_last  = axi_ret_valid && axi_ret_last;
          d_ret_data  = axi_ret_data;
        end else begin
          i_ret_valid = axi_ret_valid;
          i_ret_last  = axi_ret_valid && axi_ret_last;
          i_ret_data  = axi_ret_data;
        end
        if (axi_ret_valid && axi_ret_last) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q   <= RIdle;
      rd_owner_q   <= 1'b0;
      rd_type_q    <= 3'd0;
      rd_addr_q    <= 32'd0;
      last_grant_q <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      if (rd_start) begin
        rd_owner_q <= grant_d;
        rd_type_q  <= grant_d ? d_rd_type : i_rd_type;
        rd_addr_q  <= grant_d ? d_rd_addr : i_rd_addr;
      end
      if ((rd_state_q == RReq) && axi_rd_rdy) last_grant_q <= rd_owner_q;
    end
  end

  assign axi_wr_type  = wr_type_q;
  assign axi_wr_addr  = wr_addr_q;
  assign axi_wr_wstrb = wr_wstrb_q;
  assign axi_wr_data  = wr_data_q;

  always_comb begin
    wr_state_d = wr_state_q;
    d_wr_rdy   = 1'b0;
    axi_wr_req = 1'b0;
    unique case (wr_state_q)
      WIdle: begin
        d_wr_rdy = 1'b1;
        if (d_wr_req) wr_state_d = WReq;
      end
      WReq: begin
        // Request only once the bridge is ready so it is a single-cycle handshake.
        axi_wr_req = axi_wr_rdy;
        if (axi_wr_rdy) wr_state_d = WWait;
      end
      WWait: begin
        if (axi_wr_done) wr_state_d = WIdle;
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_q <= WIdle;
      wr_type_q  <= 3'd0;
      wr_addr_q  <= 32'd0;
      wr_wstrb_q <= 4'd0;
      wr_data_q  <= 128'd0;
    end else begin
      wr_state_q <= wr_state_d;
      if ((wr_state_q == WIdle) && d_wr_req) begin
        wr_type_q  <= d_wr_type;
        wr_addr_q  <= d_wr_addr;
        wr_wstrb_q <= d_wr_wstrb;
        wr_data_q  <= d_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scenarios followed by a randomized read-traffic run against a
// transaction-level model of the arbiter (round-robin grants, burst routing).
module tb_cache_mem_arbiter;

  logic         clk;
  logic         resetn;
  logic         i_rd_req;
  logic [2:0]   i_rd_type;
  logic [31:0]  i_rd_addr;
  logic         i_rd_rdy;
  logic         i_ret_valid;
  logic         i_ret_last;
  logic [31:0]  i_ret_data;
  logic         d_rd_req;
  logic [2:0]   d_rd_type;
  logic [31:0]  d_rd_addr;
  logic         d_rd_rdy;
  logic         d_ret_valid;
  logic         d_ret_last;
  logic [31:0]  d_ret_data;
  logic         d_wr_req;
  logic [2:0]   d_wr_type;
  logic [31:0]  d_wr_addr;
  logic [3:0]   d_wr_wstrb;
  logic [127:0] d_wr_data;
  logic         d_wr_rdy;
  logic         axi_rd_req;
  logic [2:0]   axi_rd_type;
  logic [31:0]  axi_rd_addr;
  logic         axi_rd_id;
  logic         axi_rd_rdy;
  logic         axi_ret_valid;
  logic         axi_ret_last;
  logic [31:0]  axi_ret_data;
  logic         axi_wr_req;
  logic [2:0]   axi_wr_type;
  logic [31:0]  axi_wr_addr;
  logic [3:0]   axi_wr_wstrb;
  logic [127:0] axi_wr_data;
  logic         axi_wr_rdy;
  logic         axi_wr_done;

  cache_mem_arbiter dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_rd_req      (i_rd_req),
    .i_rd_type     (i_rd_type),
    .i_rd_addr     (i_rd_addr),
    .i_rd_rdy      (i_rd_rdy),
    .i_ret_valid   (i_ret_valid),
    .i_ret_last    (i_ret_last),
    .i_ret_data    (i_ret_data),
    .d_rd_req      (d_rd_req),
    .d_rd_type     (d_rd_type),
    .d_rd_addr     (d_rd_addr),
    .d_rd_rdy      (d_rd_rdy),
    .d_ret_valid   (d_ret_valid),
    .d_ret_last    (d_ret_last),
    .d_ret_data    (d_ret_data),
    .d_wr_req      (d_wr_req),
    .d_wr_type     (d_wr_type),
    .d_wr_addr     (d_wr_addr),
    .d_wr_wstrb    (d_wr_wstrb),
    .d_wr_data     (d_wr_data),
    .d_wr_rdy      (d_wr_rdy),
    .axi_rd_req    (axi_rd_req),
    .axi_rd_type   (axi_rd_type),
    .axi_rd_addr   (axi_rd_addr),
    .axi_rd_id     (axi_rd_id),
    .axi_rd_rdy    (axi_rd_rdy),
    .axi_ret_valid (axi_ret_valid),
    .axi_ret_last  (axi_ret_last),
    .axi_ret_data  (axi_ret_data),
    .axi_wr_req    (axi_wr_req),
    .axi_wr_type   (axi_wr_type),
    .axi_wr_addr   (axi_wr_addr),
    .axi_wr_wstrb  (axi_wr_wstrb),
    .axi_wr_data   (axi_wr_data),
    .axi_wr_rdy    (axi_wr_rdy),
    .axi_wr_done   (axi_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    i_rd_req = 1'b0; i_rd_type = 3'b100; i_rd_addr = 32'd0;
    d_rd_req = 1'b0; d_rd_type = 3'b100; d_rd_addr = 32'd0;
    d_wr_req = 1'b0; d_wr_type = 3'b100; d_wr_addr = 32'd0;
    d_wr_wstrb = 4'd0; d_wr_data = 128'd0;
    axi_rd_rdy = 1'b0; axi_ret_valid = 1'b0; axi_ret_last = 1'b0; axi_ret_data = 32'd0;
    axi_wr_rdy = 1'b1; axi_wr_done = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    cyc = 0;
  endtask

  // Waits (bounded) for a read request, accepts it, then returns 4 beats base..base+3.
  task automatic run_read(input string tag, input logic exp_id, input logic [31:0] exp_addr,
                          input logic [31:0] base, output int req_cyc, output int last_cyc);
    int n = 0;
    #1;
    while (axi_rd_req !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    req_cyc = cyc;
    chk({tag, "_req"}, axi_rd_req, 1'b1);
    chk({tag, "_id"}, axi_rd_id, exp_id);
    chk({tag, "_addr"}, axi_rd_addr, exp_addr);
    axi_rd_rdy = 1'b1;
    #1;
    chk({tag, "_rdy"}, exp_id ? d_rd_rdy : i_rd_rdy, 1'b1);
    chk({tag, "_rdy_other"}, exp_id ? i_rd_rdy : d_rd_rdy, 1'b0);
    tick();
    if (exp_id) d_rd_req = 1'b0;
    else i_rd_req = 1'b0;
    axi_rd_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      axi_ret_valid = 1'b1;
      axi_ret_data  = base + 32'(k);
      axi_ret_last  = (k == 3);
      #1;
      chk({tag, "_rv"}, exp_id ? d_ret_valid : i_ret_valid, 1'b1);
      chk({tag, "_rd"}, exp_id ? d_ret_data : i_ret_data, base + 32'(k));
      chk({tag, "_rl"}, exp_id ? d_ret_last : i_ret_last, k == 3);
      chk({tag, "_rv_other"}, exp_id ? i_ret_valid : d_ret_valid, 1'b0);
      chk({tag, "_rdreq_busy"}, axi_rd_req, 1'b0);
      tick();
    end
    axi_ret_valid = 1'b0;
    axi_ret_last  = 1'b0;
    last_cyc = cyc - 1;
  endtask

  int rc, lc, lc2, done_cyc;
  // Reference model state for the random run.
  int ph, own, lastg, beat;
  bit rq[2];
  bit wt[2];
  logic [31:0] ad[2];
  bit rv;

  initial begin
    // Reset values and single icache burst.
    do_reset();
    i_rd_req = 1'b1; i_rd_addr = 32'h1C00_0010;
    #1;
    chk("rst_axi_rd_req", axi_rd_req, 1'b0);
    chk("rst_i_rd_rdy", i_rd_rdy, 1'b0);
    chk("rst_d_ret_valid", d_ret_valid, 1'b0);
    chk("rst_axi_wr_req", axi_wr_req, 1'b0);
    chk("rst_d_wr_rdy", d_wr_rdy, 1'b1);
    chk("rst_axi_rd_addr", axi_rd_addr, 32'd0);
    chk("rst_axi_wr_data", axi_wr_data, 128'd0);
    run_read("ird", 1'b0, 32'h1C00_0010, 32'hA0, rc, lc);
    chk("ird_lat", rc, 1);
    chk("ird_type", axi_rd_type, 3'b100);

    // Round-robin with both requesters held.
    do_reset();
    i_rd_req = 1'b1; i_rd_addr = 32'h0000_0100;
    d_rd_req = 1'b1; d_rd_addr = 32'h0000_0200;
    run_read("rr0", 1'b1, 32'h0000_0200, 32'h10, rc, lc);
    chk("rr0_lat", rc, 1);
    d_rd_req = 1'b1;
    run_read("rr1", 1'b0, 32'h0000_0100, 32'h20, rc, lc2);
    chk("rr1_b2b", rc, lc + 2);
    i_rd_req = 1'b1;
    run_read("rr2", 1'b1, 32'h0000_0200, 32'h30, rc, lc);
    chk("rr2_b2b", rc, lc2 + 2);

    // Read-after-write hazard on the buffered line.
    do_reset();
    d_wr_req = 1'b1; d_wr_type = 3'b100; d_wr_addr = 32'h0000_1230;
    d_wr_wstrb = 4'hF; d_wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1;
    chk("haz_wr_rdy0", d_wr_rdy, 1'b1);
    tick();
    d_wr_req = 1'b0;
    #1;
    chk("haz_wr_req", axi_wr_req, 1'b1);
    chk("haz_wr_addr", axi_wr_addr, 32'h0000_1230);
    chk("haz_wr_data", axi_wr_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("haz_wr_rdy1", d_wr_rdy, 1'b0);
    tick();
    d_rd_req = 1'b1; d_rd_addr = 32'h0000_1234;
    i_rd_req = 1'b1; i_rd_addr = 32'h0000_2000;
    #1;
    chk("haz_wr_wait", axi_wr_req, 1'b0);
    run_read("haz_i", 1'b0, 32'h0000_2000, 32'h40, rc, lc);
    chk("haz_i_lat", rc, 3);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("haz_hold", axi_rd_req, 1'b0);
      tick();
    end
    axi_wr_done = 1'b1;
    done_cyc = cyc;
    tick();
    axi_wr_done = 1'b0;
    #1;
    chk("haz_wr_free", d_wr_rdy, 1'b1);
    run_read("haz_d", 1'b1, 32'h0000_1234, 32'h50, rc, lc);
    chk("haz_d_lat", rc, done_cyc + 2);

    // Bridge not ready for writes; stray done pulse while requesting.
    do_reset();
    axi_wr_rdy = 1'b0;
    d_wr_req = 1'b1; d_wr_type = 3'b010; d_wr_addr = 32'h0000_4444;
    d_wr_wstrb = 4'b0110; d_wr_data = 128'hCAFE;
    tick();
    d_wr_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      axi_wr_done = (k == 2);
      #1;
      chk("wst_req", axi_wr_req, 1'b0);
      chk("wst_rdy", d_wr_rdy, 1'b0);
      tick();
    end
    axi_wr_done = 1'b0;
    axi_wr_rdy = 1'b1;
    #1;
    chk("wst_req_go", axi_wr_req, 1'b1);
    chk("wst_type", axi_wr_type, 3'b010);
    chk("wst_wstrb", axi_wr_wstrb, 4'b0110);
    chk("wst_addr", axi_wr_addr, 32'h0000_4444);
    tick();
    #1;
    chk("wst_req_once", axi_wr_req, 1'b0);
    chk("wst_rdy_wait", d_wr_rdy, 1'b0);
    axi_wr_done = 1'b1;
    tick();
    axi_wr_done = 1'b0;
    #1;
    chk("wst_rdy_back", d_wr_rdy, 1'b1);

    // Reset in the middle of a burst and a pending write.
    do_reset();
    axi_wr_rdy = 1'b0;
    d_wr_req = 1'b1; d_wr_addr = 32'h0000_5550; d_wr_data = 128'h5555; d_wr_wstrb = 4'hF;
    i_rd_req = 1'b1; i_rd_addr = 32'h1C00_0040;
    axi_rd_rdy = 1'b1;
    tick();
    d_wr_req = 1'b0;
    #1;
    chk("mrst_req", axi_rd_req, 1'b1);
    tick();
    i_rd_req = 1'b0; axi_rd_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      axi_ret_valid = 1'b1; axi_ret_data = 32'hB0 + 32'(k); axi_ret_last = 1'b0;
      #1;
      chk("mrst_beat", i_ret_valid, 1'b1);
      tick();
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    axi_wr_rdy = 1'b1;
    cyc = 0;
    #1;
    chk("mrst_rd_req", axi_rd_req, 1'b0);
    chk("mrst_i_ret_valid", i_ret_valid, 1'b0);
    chk("mrst_i_ret_last", i_ret_last, 1'b0);
    chk("mrst_i_ret_data", i_ret_data, 32'd0);
    chk("mrst_d_ret_valid", d_ret_valid, 1'b0);
    chk("mrst_wr_req", axi_wr_req, 1'b0);
    chk("mrst_wr_rdy", d_wr_rdy, 1'b1);
    chk("mrst_rd_addr", axi_rd_addr, 32'd0);
    chk("mrst_rd_id", axi_rd_id, 1'b0);
    chk("mrst_wr_addr", axi_wr_addr, 32'd0);
    chk("mrst_wr_data", axi_wr_data, 128'd0);
    chk("mrst_wr_wstrb", axi_wr_wstrb, 4'd0);
    axi_ret_valid = 1'b0;
    i_rd_req = 1'b1; i_rd_addr = 32'h1C00_0080;
    run_read("mrst_new", 1'b0, 32'h1C00_0080, 32'hC0, rc, lc);
    chk("mrst_new_lat", rc, 1);

    // Random read traffic against the transaction-level model.
    do_reset();
    ph = 0; own = 0; lastg = 0; beat = 0;
    rq[0] = 0; rq[1] = 0; wt[0] = 0; wt[1] = 0;
    ad[0] = 32'd0; ad[1] = 32'd0;
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < 2; c++) begin
        if (!rq[c] && !wt[c] && $urandom_range(0, 3) == 0) begin
          rq[c] = 1'b1;
          ad[c] = $urandom & 32'hFFFF_FFF0;
        end
      end
      i_rd_req = rq[0]; i_rd_addr = ad[0];
      d_rd_req = rq[1]; d_rd_addr = ad[1];
      axi_rd_rdy = 1'($urandom_range(0, 1));
      rv = (ph == 2) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      axi_ret_valid = rv;
      axi_ret_data  = $urandom;
      axi_ret_last  = (ph == 2) ? (beat == 3) : 1'($urandom_range(0, 1));
      #1;
      if (ph == 0) begin
        chk("rnd_idle_req", axi_rd_req, 1'b0);
        chk("rnd_idle_iv", i_ret_valid, 1'b0);
        chk("rnd_idle_dv", d_ret_valid, 1'b0);
        if (rq[0] || rq[1]) begin
          own = (rq[0] && rq[1]) ? (lastg ^ 1) : (rq[1] ? 1 : 0);
          ph = 1;
        end
      end else if (ph == 1) begin
        chk("rnd_req", axi_rd_req, 1'b1);
        chk("rnd_id", axi_rd_id, own[0]);
        chk("rnd_addr", axi_rd_addr, ad[own]);
        chk("rnd_rdy", own[0] ? d_rd_rdy : i_rd_rdy, axi_rd_rdy);
        chk("rnd_rdy_other", own[0] ? i_rd_rdy : d_rd_rdy, 1'b0);
        if (axi_rd_rdy) begin
          lastg = own; rq[own] = 1'b0; wt[own] = 1'b1; ph = 2; beat = 0;
        end
      end else begin
        chk("rnd_resp_req", axi_rd_req, 1'b0);
        chk("rnd_rv", own[0] ? d_ret_valid : i_ret_valid, rv);
        chk("rnd_rv_other", own[0] ? i_ret_valid : d_ret_valid, 1'b0);
        if (rv) begin
          chk("rnd_rd", own[0] ? d_ret_data : i_ret_data, axi_ret_data);
          chk("rnd_rl", own[0] ? d_ret_last : i_ret_last, beat == 3);
          if (beat == 3) begin
            ph = 0; wt[own] = 1'b0;
          end else begin
            beat++;
          end
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
